pspin_ingress_slotter: RTL

//  Consumes matched packets on the AXI-Stream leg from the packet match engine to PsPIN.

---
 rtl/pspin_ingress_slotter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pspin_ingress_slotter.sv
// Ingress slotter: writes matched AXI-Stream packets into a ring of fixed-size
// packet-buffer slots and issues one HER descriptor per committed packet.
module pspin_ingress_slotter #(
    parameter int AXIS_IF_DATA_WIDTH    = 512,
    parameter int AXIS_IF_KEEP_WIDTH    = 64,
    parameter int AXIS_IF_RX_DEST_WIDTH = 8,
    parameter int BUF_ADDR_WIDTH        = 20,
    parameter int SLOT_SIZE             = 2048,
    parameter int SLOT_COUNT            = 32,
    parameter int LEN_WIDTH             = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [AXIS_IF_DATA_WIDTH-1:0]     s_axis_pspin_rx_tdata,
    input  logic [AXIS_IF_KEEP_WIDTH-1:0]     s_axis_pspin_rx_tkeep,
    input  logic                              s_axis_pspin_rx_tvalid,
    output logic                              s_axis_pspin_rx_tready,
    input  logic                              s_axis_pspin_rx_tlast,
    input  logic [AXIS_IF_RX_DEST_WIDTH-1:0]  s_axis_pspin_rx_tdest,
    output logic [BUF_ADDR_WIDTH-1:0]         buf_wr_addr,
    output logic [AXIS_IF_DATA_WIDTH-1:0]     buf_wr_data,
    output logic [AXIS_IF_KEEP_WIDTH-1:0]     buf_wr_strb,
    output logic                              buf_wr_valid,
    input  logic                              buf_wr_ready,
    output logic [BUF_ADDR_WIDTH-1:0]         her_desc_addr,
    output logic [LEN_WIDTH-1:0]              her_desc_len,
    output logic [AXIS_IF_RX_DEST_WIDTH-1:0]  her_desc_dest,
    output logic                              her_desc_valid,
    input  logic                              her_desc_ready,
    input  logic                              free_valid,
    output logic [$clog2(SLOT_COUNT):0]       slots_used,
    output logic [31:0]                       drop_count
);
    localparam int SLOT_AW = $clog2(SLOT_SIZE);
    localparam int HEAD_W  = $clog2(SLOT_COUNT);
    localparam int USED_W  = HEAD_W + 1;
    localparam int OFF_W   = SLOT_AW + 1;

    typedef enum logic [2:0] {IDLE, STORE, DROP, DRAIN, DESC} state_t;

    state_t                             state_q, state_d;
    logic [HEAD_W-1:0]                  head_q, head_d;
    logic [OFF_W-1:0]                   off_q, off_d;
    logic [LEN_WIDTH-1:0]               len_q, len_d;
    logic [AXIS_IF_RX_DEST_WIDTH-1:0]   dest_q, dest_d;
    logic [USED_W-1:0]                  used_q, used_d;
    logic [31:0]                        drop_q, drop_d;
    logic                               wr_valid_q, wr_valid_d;
    logic [BUF_ADDR_WIDTH-1:0]          wr_addr_q, wr_addr_d;
    logic [AXIS_IF_DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic [AXIS_IF_KEEP_WIDTH-1:0]      wr_strb_q, wr_strb_d;

    logic [BUF_ADDR_WIDTH-1:0] slot_base;
    logic                      wr_load, room, tready, beat, fits, commit, freeing;

    function automatic logic [LEN_WIDTH-1:0] popcnt(input logic [AXIS_IF_KEEP_WIDTH-1:0] k);
        popcnt = '0;
        for (int i = 0; i < AXIS_IF_KEEP_WIDTH; i++) popcnt = popcnt + LEN_WIDTH'(k[i]);
    endfunction

    assign slot_base = BUF_ADDR_WIDTH'(head_q) << SLOT_AW;
    assign wr_load   = !wr_valid_q || buf_wr_ready;
    assign room      = (state_q == IDLE) && (used_q < USED_W'(SLOT_COUNT));
    // Beats are refused during reset so a mid-packet reset cannot leak a beat.
    assign tready    = !rst && ((((room || state_q == STORE) && wr_load)) || state_q == DROP);
    assign beat      = s_axis_pspin_rx_tvalid && tready;
    assign fits      = off_q <= OFF_W'(SLOT_SIZE - AXIS_IF_KEEP_WIDTH);
    assign commit    = (state_q == DESC) && her_desc_ready;
    assign freeing   = free_valid && (used_q != '0);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        off_d      = off_q;
        len_d      = len_q;
        dest_d     = dest_q;
        drop_d     = drop_q;
        wr_valid_d = wr_load ? 1'b0 : wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        case (state_q)
            IDLE: if (beat) begin
                dest_d     = s_axis_pspin_rx_tdest;
                len_d      = popcnt(s_axis_pspin_rx_tkeep);
                off_d      = OFF_W'(AXIS_IF_KEEP_WIDTH);
                wr_valid_d = 1'b1;
                wr_addr_d  = slot_base;
                wr_data_d  = s_axis_pspin_rx_tdata;
                wr_strb_d  = s_axis_pspin_rx_tkeep;
                state_d    = s_axis_pspin_rx_tlast ? DRAIN : STORE;
            end
            STORE: if (beat) begin
                if (fits) begin
                    len_d      = len_q + popcnt(s_axis_pspin_rx_tkeep);
                    off_d      = off_q + OFF_W'(AXIS_IF_KEEP_WIDTH);
                    wr_valid_d = 1'b1;
                    wr_addr_d  = slot_base + BUF_ADDR_WIDTH'(off_q);
                    wr_data_d  = s_axis_pspin_rx_tdata;
                    wr_strb_d  = s_axis_pspin_rx_tkeep;
                    if (s_axis_pspin_rx_tlast) state_d = DRAIN;
                end else begin
                    // Oversize packet: head stays put so the slot is reused.
                    if (drop_q != 32'hFFFF_FFFF) drop_d = drop_q + 32'd1;
                    state_d = s_axis_pspin_rx_tlast ? IDLE : DROP;
                end
            end
            DROP:  if (beat && s_axis_pspin_rx_tlast) state_d = IDLE;
            DRAIN: if (!wr_valid_q) state_d = DESC;
            DESC: if (her_desc_ready) begin
                head_d  = head_q + HEAD_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        used_d = used_q;
        case ({commit, freeing})
            2'b10:   used_d = used_q + USED_W'(1);
            2'b01:   used_d = used_q - USED_W'(1);
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            off_q      <= '0;
            len_q      <= '0;
            dest_q     <= '0;
            used_q     <= '0;
            drop_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            off_q      <= off_d;
            len_q      <= len_d;
            dest_q     <= dest_d;
            used_q     <= used_d;
            drop_q     <= drop_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
        end
    end

    assign s_axis_pspin_rx_tready = tready;
    assign buf_wr_addr    = wr_addr_q;
    assign buf_wr_data    = wr_data_q;
    assign buf_wr_strb    = wr_strb_q;
    assign buf_wr_valid   = wr_valid_q;
    assign her_desc_addr  = slot_base;
    assign her_desc_len   = len_q;
    assign her_desc_dest  = dest_q;
    assign her_desc_valid = (state_q == DESC);
    assign slots_used     = used_q;
    assign drop_count     = drop_q;

endmodule
